// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one variable-latency memory port between fetch and data access
module mem_port_arbiter #(
  parameter int AW      = 64,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [31:0]   if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [7:0]    dm_strb,
  input  logic [AW-1:0] dm_addr,
  input  logic [63:0]   dm_wdata,
  output logic [63:0]   dm_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [7:0]    mem_strb,
  output logic [AW-1:0] mem_addr,
  output logic [63:0]   mem_wdata,
  input  logic [63:0]   mem_rdata,
  input  logic          mem_ack,
  output logic          waiting,
  output logic          mem_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    D_BUSY = 2'd1,
    I_BUSY = 2'd2
  } state_e;

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

  state_e        state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [7:0]    mem_strb_q, mem_strb_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [63:0]   mem_wdata_q, mem_wdata_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic [63:0]   dm_rdata_q, dm_rdata_d;
  logic          dm_srv_q, dm_srv_d;
  logic          if_srv_q, if_srv_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          err_q, err_d;

  logic          dm_pend;
  logic          if_pend;
  logic [7:0]    cnt_inc;

  // A port is pending until it has been served in the current pipeline cycle
  assign dm_pend = dm_req & ~dm_srv_q;
  assign if_pend = if_req & ~if_srv_q;
  assign waiting = dm_pend | if_pend;

  // Saturating busy-cycle counter so a stuck memory cannot wrap it back below the limit
  assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_strb  = mem_strb_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign mem_err   = err_q;

  // Next-state: issue selection (data first), completion capture and timeout detection
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_strb_d  = mem_strb_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    dm_srv_d    = dm_srv_q;
    if_srv_d    = if_srv_q;
    cnt_d       = cnt_q;
    err_d       = err_q;

    // Pipeline advances this cycle, so next cycle's requests are fresh
    if (!waiting) begin
      dm_srv_d = 1'b0;
      if_srv_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (dm_pend) begin
          state_d     = D_BUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_strb_d  = dm_we ? dm_strb : 8'hFF;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          cnt_d       = 8'd0;
        end else if (if_pend) begin
          state_d     = I_BUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_strb_d  = 8'hFF;
          mem_addr_d  = if_addr;
          cnt_d       = 8'd0;
        end
      end
      D_BUSY, I_BUSY: begin
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (state_q == D_BUSY) begin
            dm_srv_d = 1'b1;
            if (!mem_we_q) begin
              dm_rdata_d = mem_rdata;
            end
          end else begin
            // Latched fetch address picks the 32-bit half of the 64-bit beat
            if_srv_d   = 1'b1;
            if_rdata_d = mem_addr_q[2] ? mem_rdata[63:32] : mem_rdata[31:0];
          end
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TO_LIMIT) begin
            err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any in-flight access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_strb_q  <= 8'h00;
      mem_addr_q  <= '0;
      mem_wdata_q <= 64'h0;
      if_rdata_q  <= 32'h0;
      dm_rdata_q  <= 64'h0;
      dm_srv_q    <= 1'b0;
      if_srv_q    <= 1'b0;
      cnt_q       <= 8'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_strb_q  <= mem_strb_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      dm_srv_q    <= dm_srv_d;
      if_srv_q    <= if_srv_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

  typedef struct {
    logic        we;
    logic [7:0]  strb;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        chk_wdata;
  } mem_txn_t;

  typedef struct {
    bit          is_if;
    logic [63:0] val;
  } rd_exp_t;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [63:0] if_addr;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [7:0]  dm_strb;
  logic [63:0] dm_addr;
  logic [63:0] dm_wdata;
  logic [63:0] dm_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [7:0]  mem_strb;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_ack;
  logic        waiting;
  logic        mem_err;

  int tests_run = 0;
  int tests_failed = 0;

  mem_txn_t    exp_mem_q[$];
  rd_exp_t     exp_rd_q[$];
  mem_txn_t    issued[0:63];
  logic [63:0] resp_data[0:63];
  int          issue_cnt = 0;
  int          push_idx = 0;
  int          chk_idx = 0;
  int          ack_delay = 0;
  bit          ack_block = 1'b0;
  int          late_req = 0;
  logic [63:0] last_dm = 64'h0;

  mem_port_arbiter #(.AW(64), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_strb(dm_strb), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_strb(mem_strb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .waiting(waiting), .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: logs each new request, acks after ack_delay extra cycles
  initial begin : mem_responder
    int cd;
    bit active;
    int late_done;
    logic [63:0] cur;
    cd = 0; active = 1'b0; late_done = 0; cur = 64'h0;
    mem_ack = 1'b0;
    mem_rdata = 64'h0;
    forever begin
      @(posedge clk); #1;
      if (mem_ack) begin
        mem_ack = 1'b0;
        active = 1'b0;
      end
      if (!rst_n) begin
        active = 1'b0;
      end else if (late_req != late_done) begin
        late_done = late_req;
        mem_ack = 1'b1;
        mem_rdata = 64'hFEEDFACE_CAFEF00D;
      end else if (active) begin
        if (cd > 0) cd--;
        else if (!ack_block) begin
          mem_ack = 1'b1;
          mem_rdata = cur;
        end
      end else if (mem_req && issue_cnt < 64) begin
        active = 1'b1;
        cd = ack_delay;
        issued[issue_cnt].we = mem_we;
        issued[issue_cnt].strb = mem_strb;
        issued[issue_cnt].addr = mem_addr;
        issued[issue_cnt].wdata = mem_wdata;
        issued[issue_cnt].chk_wdata = 1'b0;
        cur = resp_data[issue_cnt];
        issue_cnt++;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic expect_mem(input logic we, input logic [7:0] strb, input logic [63:0] addr,
                            input logic [63:0] wdata, input logic chk_wdata, input logic [63:0] rdata);
    mem_txn_t t;
    t.we = we; t.strb = strb; t.addr = addr; t.wdata = wdata; t.chk_wdata = chk_wdata;
    exp_mem_q.push_back(t);
    resp_data[push_idx] = rdata;
    push_idx++;
  endtask

  task automatic push_rd(input bit is_if, input logic [63:0] val);
    rd_exp_t r;
    r.is_if = is_if; r.val = val;
    exp_rd_q.push_back(r);
  endtask

  function automatic logic [63:0] fetch_half(input logic [63:0] addr, input logic [63:0] beat);
    return addr[2] ? {32'h0, beat[63:32]} : {32'h0, beat[31:0]};
  endfunction

  task automatic check_issues(input string name);
    mem_txn_t a, e;
    while (chk_idx < issue_cnt) begin
      a = issued[chk_idx];
      chk_idx++;
      tests_run++;
      if (exp_mem_q.size() == 0) begin
        tests_failed++;
        $display("FAIL %s issue: unexpected access addr=%h we=%b", name, a.addr, a.we);
      end else begin
        e = exp_mem_q.pop_front();
        if (a.addr !== e.addr || a.we !== e.we || a.strb !== e.strb ||
            (e.chk_wdata && a.wdata !== e.wdata)) begin
          tests_failed++;
          $display("FAIL %s issue: got addr=%h we=%b strb=%h wdata=%h, want addr=%h we=%b strb=%h wdata=%h",
                   name, a.addr, a.we, a.strb, a.wdata, e.addr, e.we, e.strb, e.wdata);
        end
      end
    end
    tests_run++;
    if (exp_mem_q.size() != 0) begin
      tests_failed++;
      $display("FAIL %s lost: %0d expected accesses never issued", name, exp_mem_q.size());
      exp_mem_q.delete();
    end
  endtask

  task automatic check_rd(input string name);
    rd_exp_t r;
    logic [63:0] got;
    while (exp_rd_q.size() != 0) begin
      r = exp_rd_q.pop_front();
      got = r.is_if ? {32'h0, if_rdata} : dm_rdata;
      tests_run++;
      if (got !== r.val) begin
        tests_failed++;
        $display("FAIL %s %s: got %h want %h", name, r.is_if ? "if_rdata" : "dm_rdata", got, r.val);
      end
    end
  endtask

  task automatic wait_release(input string name, input int budget, output int n, output int ack_n);
    n = 0; ack_n = -1;
    while (waiting === 1'b1 && n < budget) begin
      tick();
      n++;
      if (mem_ack === 1'b1) ack_n = n;
    end
    tests_run++;
    if (waiting !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s release: waiting=%b after %0d cycles, want 0", name, waiting, n);
    end
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    if_req = 1'b0; if_addr = 64'h0;
    dm_req = 1'b0; dm_we = 1'b0; dm_strb = 8'h0; dm_addr = 64'h0; dm_wdata = 64'h0;
    ack_block = 1'b0; ack_delay = 0;
    repeat (3) tick();
    tests_run++;
    if ({mem_req, mem_we, mem_err, waiting} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset ctrl: req/we/err/waiting=%b want 0000", {mem_req, mem_we, mem_err, waiting});
    end
    tests_run++;
    if (mem_strb !== 8'h0 || mem_addr !== 64'h0 || mem_wdata !== 64'h0) begin
      tests_failed++;
      $display("FAIL reset memout: strb=%h addr=%h wdata=%h want 0", mem_strb, mem_addr, mem_wdata);
    end
    tests_run++;
    if (if_rdata !== 32'h0 || dm_rdata !== 64'h0) begin
      tests_failed++;
      $display("FAIL reset rdata: if=%h dm=%h want 0", if_rdata, dm_rdata);
    end
    rst_n = 1'b1;
    tick();
    ack_block = 1'b1;
    dm_req = 1'b1; dm_addr = 64'h6000;
    expect_mem(1'b0, 8'hFF, 64'h6000, 64'h0, 1'b0, 64'h1111_2222_3333_4444);
    n = 0;
    while (mem_req !== 1'b1 && n < 10) begin tick(); n++; end
    tests_run++;
    if (mem_req !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset issue: mem_req=%b want 1", mem_req);
    end
    #1 rst_n = 1'b0;
    #1;
    tests_run++;
    if (mem_req !== 1'b0 || waiting !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset async: mem_req=%b waiting=%b want 0 1", mem_req, waiting);
    end
    dm_req = 1'b0;
    #1;
    tests_run++;
    if (waiting !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset waiting: got %b want 0", waiting);
    end
    tick();
    rst_n = 1'b1;
    ack_block = 1'b0;
    tick();
    late_req++;
    tick();
    tests_run++;
    if (mem_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset late ack: mem_req=%b want 0", mem_req);
    end
    tick();
    tests_run++;
    if (mem_req !== 1'b0 || dm_rdata !== 64'h0 || if_rdata !== 32'h0 || waiting !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset after ack: req=%b dm=%h if=%h waiting=%b want 0 0 0 0",
               mem_req, dm_rdata, if_rdata, waiting);
    end
    check_issues("reset");
  endtask

  task automatic test_fetch();
    int n, ack_n;
    tick();
    ack_block = 1'b0; ack_delay = 2;
    dm_req = 1'b0; if_req = 1'b1; if_addr = 64'h1004;
    expect_mem(1'b0, 8'hFF, 64'h1004, 64'h0, 1'b0, 64'hDEADBEEF_00000013);
    push_rd(1'b1, 64'h0000_0000_DEADBEEF);
    #1;
    tests_run++;
    if (waiting !== 1'b1) begin
      tests_failed++;
      $display("FAIL fetch waiting: got %b want 1", waiting);
    end
    wait_release("fetch", 20, n, ack_n);
    tests_run++;
    if (n != 5 || ack_n != 4) begin
      tests_failed++;
      $display("FAIL fetch latency: ack at %0d release at %0d, want 4 5", ack_n, n);
    end
    check_rd("fetch");
    tests_run++;
    if (mem_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL fetch mem_err: got %b want 0", mem_err);
    end
    check_issues("fetch");
  endtask

  task automatic test_contention();
    int n, ack_n;
    tick();
    ack_delay = 0;
    dm_req = 1'b1; dm_we = 1'b0; dm_strb = 8'h00; dm_addr = 64'h2000; dm_wdata = 64'h0;
    if_req = 1'b1; if_addr = 64'h3000;
    expect_mem(1'b0, 8'hFF, 64'h2000, 64'h0, 1'b0, 64'h01234567_89ABCDEF);
    expect_mem(1'b0, 8'hFF, 64'h3000, 64'h0, 1'b0, 64'hAAAA5555_13579BDF);
    push_rd(1'b0, 64'h01234567_89ABCDEF);
    push_rd(1'b1, 64'h0000_0000_13579BDF);
    last_dm = 64'h01234567_89ABCDEF;
    wait_release("contention", 30, n, ack_n);
    tests_run++;
    if (n != 6 || ack_n != 5) begin
      tests_failed++;
      $display("FAIL contention latency: last ack %0d release %0d, want 5 6", ack_n, n);
    end
    check_rd("contention");
    check_issues("contention");
  endtask

  task automatic test_store();
    int n, ack_n;
    tick();
    ack_delay = 1;
    if_req = 1'b0;
    dm_req = 1'b1; dm_we = 1'b1; dm_strb = 8'h0F; dm_addr = 64'h4008;
    dm_wdata = 64'h11223344_55667788;
    expect_mem(1'b1, 8'h0F, 64'h4008, 64'h11223344_55667788, 1'b1, 64'hBADBADBA_DBADBAD0);
    push_rd(1'b0, last_dm);
    wait_release("store", 20, n, ack_n);
    tests_run++;
    if (n != 4) begin
      tests_failed++;
      $display("FAIL store latency: release at %0d want 4", n);
    end
    check_rd("store");
    check_issues("store");
  endtask

  task automatic test_streaming();
    int n, ack_n;
    logic [63:0] a, beat;
    ack_delay = 0;
    tick();
    dm_req = 1'b0; dm_we = 1'b0;
    for (int i = 0; i < 10; i++) begin
      a = 64'h200 + 64'(4 * i);
      beat = {32'hC0DE0000 + 32'(i), 32'h00001000 + 32'(i)};
      if_req = 1'b1; if_addr = a;
      expect_mem(1'b0, 8'hFF, a, 64'h0, 1'b0, beat);
      push_rd(1'b1, fetch_half(a, beat));
      wait_release("stream", 10, n, ack_n);
      tests_run++;
      if (n != 3) begin
        tests_failed++;
        $display("FAIL stream latency #%0d: release at %0d want 3", i, n);
      end
      check_rd("stream");
      tick();
    end
    if_req = 1'b0;
    check_issues("stream");
  endtask

  task automatic test_timeout();
    int n, ack_n;
    ack_delay = 0; ack_block = 1'b1;
    if_req = 1'b0;
    dm_req = 1'b1; dm_we = 1'b0; dm_strb = 8'h00; dm_addr = 64'h5000;
    expect_mem(1'b0, 8'hFF, 64'h5000, 64'h0, 1'b0, 64'h5555AAAA_0F0F0F0F);
    push_rd(1'b0, 64'h5555AAAA_0F0F0F0F);
    n = 0;
    while (mem_req !== 1'b1 && n < 10) begin tick(); n++; end
    repeat (3) tick();
    tests_run++;
    if (mem_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout early: mem_err=%b after 3 busy cycles, want 0", mem_err);
    end
    tick();
    tests_run++;
    if (mem_err !== 1'b1 || waiting !== 1'b1) begin
      tests_failed++;
      $display("FAIL timeout set: mem_err=%b waiting=%b after 4 busy cycles, want 1 1", mem_err, waiting);
    end
    ack_block = 1'b0;
    wait_release("timeout", 10, n, ack_n);
    check_rd("timeout");
    tests_run++;
    if (mem_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL timeout sticky: mem_err=%b want 1", mem_err);
    end
    check_issues("timeout");
    tick();
    dm_req = 1'b0;
  endtask

  initial begin : main
    test_reset();
    test_fetch();
    test_contention();
    test_store();
    test_streaming();
    test_timeout();
    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
